// File: rtl/valve_sequencer.sv
// Sequences four zone valves from upstream commands: staggered opening, minimum on-time,
// filtered fault latching with operator-acknowledged recovery, pump enable and alarm outputs.
module valve_sequencer #(
  parameter int STAGGER    = 4,
  parameter int MIN_ON     = 8,
  parameter int FAULT_FILT = 3,
  parameter int HOLDOFF    = 16,
  parameter int CW         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] R1,
  input  logic [1:0] R2,
  input  logic [1:0] E,
  input  logic       ack,
  output logic [3:0] V,
  output logic       pump_en,
  output logic       alarm,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_FAULT   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  localparam logic [CW-1:0] STAG_LD  = CW'(STAGGER - 1);
  localparam logic [CW-1:0] ON_LD    = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] FLT_LAST = CW'(FAULT_FILT - 1);
  localparam logic [CW-1:0] REC_LD   = CW'(HOLDOFF - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t        state_q;
  logic [3:0]    req_q;
  logic [3:0]    v_q;
  logic          pump_q;
  logic          alarm_q;
  logic [CW-1:0] stag_q;
  logic [CW-1:0] flt_q;
  logic [CW-1:0] rec_q;
  logic [CW-1:0] on_q [4];

  logic [3:0]    cand;
  logic [3:0]    open_oh;
  logic [3:0]    close_m;
  logic [3:0]    v_d;
  logic [CW-1:0] stag_d;
  logic          found;
  logic          e_ok;

  assign e_ok = (E == 2'b01);

  // Lowest-index pending valve wins; at most one opening per edge, gated by the stagger timer.
  always_comb begin
    cand    = req_q & ~v_q;
    open_oh = '0;
    close_m = '0;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cand[i] && !found && (stag_q == '0)) begin
        open_oh[i] = 1'b1;
        found      = 1'b1;
      end
      close_m[i] = v_q[i] & ~req_q[i] & (on_q[i] == '0);
    end
    v_d    = (v_q & ~close_m) | open_oh;
    stag_d = (|open_oh) ? STAG_LD : ((stag_q != '0) ? stag_q - ONE : '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_RUN;
      req_q   <= '0;
      v_q     <= '0;
      pump_q  <= 1'b0;
      alarm_q <= 1'b0;
      stag_q  <= '0;
      flt_q   <= '0;
      rec_q   <= '0;
      for (int i = 0; i < 4; i++) on_q[i] <= '0;
    end else begin
      req_q  <= {R1, R2};
      pump_q <= |v_q;
      case (state_q)
        S_RUN: begin
          if (!e_ok && (flt_q == FLT_LAST)) begin
            state_q <= S_FAULT;
            v_q     <= '0;
            alarm_q <= 1'b1;
            flt_q   <= '0;
          end else begin
            flt_q  <= e_ok ? '0 : flt_q + ONE;
            v_q    <= v_d;
            stag_q <= stag_d;
            for (int i = 0; i < 4; i++) begin
              on_q[i] <= open_oh[i] ? ON_LD : ((on_q[i] != '0) ? on_q[i] - ONE : '0);
            end
          end
        end
        S_FAULT: begin
          v_q     <= '0;
          alarm_q <= 1'b1;
          flt_q   <= '0;
          if (ack && e_ok) begin
            state_q <= S_RECOVER;
            alarm_q <= 1'b0;
            rec_q   <= REC_LD;
          end
        end
        S_RECOVER: begin
          v_q   <= '0;
          flt_q <= '0;
          if (!e_ok) begin
            state_q <= S_FAULT;
            alarm_q <= 1'b1;
          end else if (rec_q == '0) begin
            state_q <= S_RUN;
            stag_q  <= '0;
            for (int i = 0; i < 4; i++) on_q[i] <= '0;
          end else begin
            rec_q <= rec_q - ONE;
          end
        end
        default: begin
          state_q <= S_FAULT;
          v_q     <= '0;
          alarm_q <= 1'b1;
          flt_q   <= '0;
        end
      endcase
    end
  end

  assign V       = v_q;
  assign pump_en = pump_q;
  assign alarm   = alarm_q;
  assign busy    = (state_q != S_RUN) | (|(req_q & ~v_q));

endmodule

// File: tb/tb_valve_sequencer.sv
// Directed bench for valve_sequencer: expected {V,pump_en,alarm,busy} per edge is queued, then popped and compared.
module tb_valve_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] R1, R2, E;
  logic       ack;
  logic [3:0] V;
  logic       pump_en, alarm, busy;

  always #5 clk = ~clk;

  valve_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .R1      (R1),
    .R2      (R2),
    .E       (E),
    .ack     (ack),
    .V       (V),
    .pump_en (pump_en),
    .alarm   (alarm),
    .busy    (busy)
  );

  localparam logic [6:0] ALL    = 7'b1111111;
  localparam logic [6:0] NOBUSY = 7'b1111110;

  string      tag_q [$];
  logic [6:0] val_q [$];
  logic [6:0] msk_q [$];
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic check_front();
    string      t;
    logic [6:0] ev, em, obs;
    t   = tag_q.pop_front();
    ev  = val_q.pop_front();
    em  = msk_q.pop_front();
    obs = {V, pump_en, alarm, busy};
    n_chk++;
    assert ((obs & em) === (ev & em)) begin
      n_pass++;
    end else begin
      $error("FAIL %s: V/pump/alarm/busy observed=%b expected=%b mask=%b", t, obs, ev, em);
    end
  endtask

  // Push the expectation for the coming edge, advance past it, then compare.
  task automatic step(input string tag, input logic [3:0] v, input logic p, input logic a,
                      input logic b, input logic [6:0] msk);
    tag_q.push_back(tag);
    val_q.push_back({v, p, a, b});
    msk_q.push_back(msk);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0; R1 = 2'b11; R2 = 2'b00; E = 2'b01; ack = 1'b0;

    // Reset with zone-1 requests pending, then stagger V[2] -> V[3]
    step("rst_e0", 4'b0000, 0, 0, 0, NOBUSY);
    step("rst_e1", 4'b0000, 0, 0, 0, NOBUSY);
    reset = 1'b1;
    step("t1_req_sampled", 4'b0000, 0, 0, 1, ALL);
    step("t1_open_v2",     4'b0100, 0, 0, 1, ALL);
    step("t1_pump_on",     4'b0100, 1, 0, 1, ALL);
    step("t1_stag_wait1",  4'b0100, 1, 0, 1, ALL);
    step("t1_stag_wait2",  4'b0100, 1, 0, 1, ALL);
    step("t1_open_v3",     4'b1100, 1, 0, 0, ALL);

    // Fill all four valves, then reset mid-operation
    R2 = 2'b11;
    step("t6_hold_stag",   4'b1100, 1, 0, 1, ALL);
    idle(2);
    step("t6_open_v0",     4'b1101, 1, 0, 1, ALL);
    idle(3);
    step("t6_open_v1",     4'b1111, 1, 0, 0, ALL);
    reset = 1'b0;
    step("t6_reset_clear", 4'b0000, 0, 0, 0, ALL);
    reset = 1'b1;
    step("t6_rel_sample",  4'b0000, 0, 0, 1, ALL);
    step("t6_restart_v0",  4'b0001, 0, 0, 1, ALL);
    idle(2);
    step("t6_stag_hold",   4'b0001, 1, 0, 1, ALL);
    step("t6_open_v1",     4'b0011, 1, 0, 1, ALL);

    R1 = 2'b00; R2 = 2'b00;
    idle(20);
    step("drain_closed",   4'b0000, 0, 0, 0, ALL);

    // Single-cycle request holds V[1] for exactly MIN_ON cycles
    R2 = 2'b10;
    step("t3_sample",      4'b0000, 0, 0, 1, ALL);
    R2 = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      step($sformatf("t3_min_on_%0d", k), 4'b0010, (k >= 2), 0, 0, ALL);
    end
    step("t3_close",       4'b0000, 1, 0, 0, ALL);
    step("t3_pump_off",    4'b0000, 0, 0, 0, ALL);

    // Stagger between V[0] and V[2]
    R1 = 2'b01; R2 = 2'b01;
    step("t2_sample",      4'b0000, 0, 0, 1, ALL);
    step("t2_open_v0",     4'b0001, 0, 0, 1, ALL);
    step("t2_pump_on",     4'b0001, 1, 0, 1, ALL);
    idle(2);
    step("t2_open_v2",     4'b0101, 1, 0, 0, ALL);

    // Fault filter: two bad samples are forgiven, three latch
    E = 2'b00;
    step("t4_bad1",        4'b0101, 1, 0, 0, ALL);
    step("t4_bad2",        4'b0101, 1, 0, 0, ALL);
    E = 2'b01;
    step("t4_good_clears", 4'b0101, 1, 0, 0, ALL);
    E = 2'b00;
    step("t4_bad1_again",  4'b0101, 1, 0, 0, ALL);
    step("t4_bad2_again",  4'b0101, 1, 0, 0, ALL);
    step("t4_fault_latch", 4'b0000, 1, 1, 1, ALL);
    step("t4_pump_off",    4'b0000, 0, 1, 1, ALL);

    // Acknowledge ignored while E faulty, then hold-off before RUN
    ack = 1'b1; E = 2'b10;
    step("t5_ack_ignored", 4'b0000, 0, 1, 1, ALL);
    E = 2'b01;
    step("t5_enter_recov", 4'b0000, 0, 0, 1, ALL);
    ack = 1'b0;
    for (int k = 3; k <= 17; k++) begin
      step($sformatf("t5_recover_%0d", k), 4'b0000, 0, 0, 1, ALL);
    end
    step("t5_back_to_run", 4'b0000, 0, 0, 1, ALL);
    step("t5_open_v0",     4'b0001, 0, 0, 1, ALL);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
